// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronises the raw pins, deframes 11-bit frames
// into scan-code bytes and buffers them in a small FIFO for the decoder.
module ps2_rx_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int TIMEOUT    = 100000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    state_t              state_q, state_d;
    logic [2:0]          clk_sync_q, clk_sync_d;
    logic [2:0]          data_sync_q, data_sync_d;
    logic [3:0]          bitcnt_q, bitcnt_d;
    logic [9:0]          shreg_q, shreg_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic                overflow_q, overflow_d;
    logic                frame_err_q, frame_err_d;
    logic [7:0]          mem_q [DEPTH];

    logic fall, bit_in, empty, full, pop, accept, push, drop;

    always_comb begin
        clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
        data_sync_d = {data_sync_q[1:0], ps2_data};
        fall   = (clk_sync_q[2:1] == 2'b10);
        bit_in = data_sync_q[2];

        empty  = (wr_ptr_q == rd_ptr_q);
        full   = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
        pop    = !empty && !nextdata_n;
        // shreg holds {stop, parity, data[7:0]} once all ten bits have shifted in
        accept = shreg_q[9] && (^shreg_q[8:0]);
        push   = (state_q == CHECK) && accept && (!full || pop);
        drop   = (state_q == CHECK) && accept && full && !pop;

        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        tmo_d       = tmo_q;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (fall && !bit_in) begin
                    state_d  = SHIFT;
                    bitcnt_d = 4'd0;
                end
            end
            SHIFT: begin
                if (fall) begin
                    shreg_d = {bit_in, shreg_q[9:1]};
                    tmo_d   = '0;
                    if (bitcnt_q == 4'd9) state_d = CHECK;
                    else                  bitcnt_d = bitcnt_q + 4'd1;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    // keyboard stalled mid-frame: drop the partial byte
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                    tmo_d       = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            CHECK: begin
                frame_err_d = !accept;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        overflow_d = overflow_q;
        if (pop)  overflow_d = 1'b0;
        if (drop) overflow_d = 1'b1;

        wr_ptr_d = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (clrn) begin
            state_q     <= IDLE;
            clk_sync_q  <= 3'b111;
            data_sync_q <= 3'b111;
            bitcnt_q    <= 4'd0;
            shreg_q     <= 10'd0;
            tmo_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            tmo_q       <= tmo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
            if (push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= shreg_q[7:0];
        end
    end

    assign data      = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign ready     = !empty;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: frames are bit-banged on the PS/2 pins,
// expected bytes are queued as frames are sent and compared on each pop.
module tb_ps2_rx_fifo;
    localparam int TO   = 300;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       clrn = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready, overflow, frame_err;

    int total = 0;
    int bad = 0;
    int err_cnt = 0;
    logic [7:0] exp_q [$];
    logic       ovf_m = 1'b0;

    ps2_rx_fifo #(.DEPTH_LOG2(3), .TIMEOUT(TO)) dut (
        .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .nextdata_n(nextdata_n), .data(data), .ready(ready),
        .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_err === 1'b1) err_cnt++;

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // mode 0: plain; 1: pop during the CHECK cycle; 2: check push latency
    task automatic send_frame(input logic [7:0] b, input logic bad_par,
                              input logic bad_stop, input int mode);
        logic [10:0] f;
        logic        valid;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        valid = !bad_par && !bad_stop;
        for (int i = 0; i < 10; i++) send_bit(f[i]);
        ps2_data = f[10];
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        if (mode == 1) begin
            total++;
            if (ready !== 1'b1 || exp_q.size() == 0 || data !== exp_q[0]) begin
                bad++;
                $display("FAIL pop_at_check head: ready=%b data=%h", ready, data);
            end
            nextdata_n = 1'b0;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            ovf_m = 1'b0;
        end
        if (mode == 2) begin
            total++;
            if (ready !== 1'b0) begin
                bad++;
                $display("FAIL latency_check_cycle: ready=%b want 0", ready);
            end
        end
        @(negedge clk);
        nextdata_n = 1'b1;
        if (mode == 2) begin
            total++;
            if (ready !== 1'b1 || data !== b) begin
                bad++;
                $display("FAIL latency_ready: ready=%b data=%h want 1/%h", ready, data, b);
            end
        end
        if (valid) begin
            if (exp_q.size() < 8) exp_q.push_back(b);
            else ovf_m = 1'b1;
        end
        repeat (HALF - 4) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        total++;
        if (ready !== (exp_q.size() > 0) || overflow !== ovf_m) begin
            bad++;
            $display("FAIL frame_status %h: ready=%b ovf=%b want %b/%b",
                     b, ready, overflow, exp_q.size() > 0, ovf_m);
        end
    endtask

    task automatic pop_one();
        logic [7:0] e;
        @(negedge clk);
        total++;
        if (exp_q.size() == 0) begin
            if (ready !== 1'b0) begin
                bad++;
                $display("FAIL pop_empty: ready=%b want 0", ready);
            end
            return;
        end
        e = exp_q.pop_front();
        if (ready !== 1'b1 || data !== e) begin
            bad++;
            $display("FAIL pop_data: ready=%b data=%h want 1/%h", ready, data, e);
        end
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
        ovf_m = 1'b0;
        total++;
        if (overflow !== ovf_m || ready !== (exp_q.size() > 0)) begin
            bad++;
            $display("FAIL after_pop: ovf=%b ready=%b want %b/%b",
                     overflow, ready, ovf_m, exp_q.size() > 0);
        end
    endtask

    task automatic do_reset();
        clrn = 1'b1;
        repeat (3) @(negedge clk);
        clrn = 1'b0;
        exp_q.delete();
        ovf_m = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (ready !== 1'b0 || overflow !== 1'b0 || frame_err !== 1'b0 || data !== 8'h00) begin
            bad++;
            $display("FAIL reset: ready=%b ovf=%b ferr=%b data=%h want 0/0/0/00",
                     ready, overflow, frame_err, data);
        end
    endtask

    task automatic test_single();
        send_frame(8'h1C, 1'b0, 1'b0, 2);
        pop_one();
    endtask

    task automatic test_two();
        send_frame(8'hF0, 1'b0, 1'b0, 0);
        send_frame(8'h1C, 1'b0, 1'b0, 0);
        pop_one();
        pop_one();
        pop_one();
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, 0);
        for (int i = 0; i < 8; i++) pop_one();
        pop_one();
    endtask

    task automatic test_errors();
        int e0;
        e0 = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b0, 0);
        total++;
        if (err_cnt - e0 !== 1) begin
            bad++;
            $display("FAIL bad_parity: pulses=%0d want 1", err_cnt - e0);
        end
        e0 = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, 0);
        total++;
        if (err_cnt - e0 !== 1 || ready !== 1'b0) begin
            bad++;
            $display("FAIL bad_stop: pulses=%0d ready=%b want 1/0", err_cnt - e0, ready);
        end
    endtask

    task automatic test_timeout();
        int e0;
        e0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        repeat (TO + 10) @(negedge clk);
        total++;
        if (err_cnt - e0 !== 1 || ready !== 1'b0) begin
            bad++;
            $display("FAIL timeout: pulses=%0d ready=%b want 1/0", err_cnt - e0, ready);
        end
        send_frame(8'h5A, 1'b0, 1'b0, 0);
        pop_one();
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 8; i++) send_frame(8'h40 + 8'(i), 1'b0, 1'b0, 0);
        send_frame(8'hA5, 1'b0, 1'b0, 1);
        total++;
        if (exp_q.size() !== 8 || exp_q[7] !== 8'hA5) begin
            bad++;
            $display("FAIL model_full_pop: size=%0d", exp_q.size());
        end
        for (int i = 0; i < 8; i++) pop_one();
        pop_one();
    endtask

    task automatic test_reset_mid_frame();
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        do_reset();
        send_frame(8'h33, 1'b0, 1'b0, 0);
        pop_one();
        pop_one();
    endtask

    initial begin
        test_reset();
        test_single();
        test_two();
        test_overflow();
        test_errors();
        test_timeout();
        test_full_pop();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
